// File: rtl/cache_ctrl_2way.sv
// 2-way set-associative, write-back / write-allocate cache controller.
// One word per line, LRU replacement per set, tag/data held in registers.
// Sits in front of a single-port synchronous RAM and keeps saturating hit/miss counts.
module cache_ctrl_2way #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned INDEX_W = 1,
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned STAT_W  = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              req,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data,
    input  logic              wren,
    output logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] q,
    output logic              hit,
    output logic [STAT_W-1:0] hit_count,
    output logic [STAT_W-1:0] miss_count,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    localparam int unsigned SETS  = 2 ** INDEX_W;
    localparam int unsigned TAG_W = ADDR_W - INDEX_W;
    localparam int unsigned LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        FILL,
        RESPOND
    } stateT;

    stateT state;
    stateT nextState;

    // Latched request
    logic [ADDR_W-1:0] reqAddr;
    logic [DATA_W-1:0] reqData;
    logic              reqWren;

    // Line storage, indexed [set][way]
    logic [SETS-1:0][1:0][TAG_W-1:0]  tagMem;
    logic [SETS-1:0][1:0][DATA_W-1:0] dataMem;
    logic [SETS-1:0][1:0]             validBits;
    logic [SETS-1:0][1:0]             dirtyBits;
    logic [SETS-1:0]                  lruBits;   // way to replace next

    logic              victimWay;
    logic [LAT_W-1:0]  fillCnt;
    logic [DATA_W-1:0] respData;
    logic              respHit;

    // Combinational lookup results
    logic [INDEX_W-1:0] reqIndex;
    logic [TAG_W-1:0]   reqTag;
    logic [1:0]         wayHit;
    logic               lookupHit;
    logic               hitWay;
    logic               victimSel;
    logic               victimDirty;
    logic               fillDone;

    // Registered-output next values
    logic              readyNext;
    logic              validNext;
    logic              memWrenNext;
    logic [ADDR_W-1:0] memAddrNext;
    logic [DATA_W-1:0] memDataNext;

    // Tag compare and victim selection for the latched request
    always_comb begin
        reqIndex    = reqAddr[INDEX_W-1:0];
        reqTag      = reqAddr[ADDR_W-1:INDEX_W];
        wayHit[0]   = validBits[reqIndex][0] && (tagMem[reqIndex][0] == reqTag);
        wayHit[1]   = validBits[reqIndex][1] && (tagMem[reqIndex][1] == reqTag);
        lookupHit   = |wayHit;
        hitWay      = ~wayHit[0];
        if (!validBits[reqIndex][0]) begin
            victimSel = 1'b0;
        end else if (!validBits[reqIndex][1]) begin
            victimSel = 1'b1;
        end else begin
            victimSel = lruBits[reqIndex];
        end
        victimDirty = validBits[reqIndex][victimSel] && dirtyBits[reqIndex][victimSel];
        fillDone    = reqWren || (fillCnt == LAT_W'(MEM_LAT - 1));
    end

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode
    always_comb begin
        nextState = state;
        case (state)
            IDLE:      if (req && ready) nextState = LOOKUP;
            LOOKUP: begin
                if (lookupHit) begin
                    nextState = RESPOND;
                end else if (victimDirty) begin
                    nextState = WRITEBACK;
                end else begin
                    nextState = FILL;
                end
            end
            WRITEBACK: nextState = FILL;
            FILL:      if (fillDone) nextState = RESPOND;
            RESPOND:   nextState = IDLE;
            default:   nextState = IDLE;
        endcase
    end

    // Next values of the handshake and RAM-port outputs
    always_comb begin
        readyNext   = (nextState == IDLE);
        validNext   = (state == RESPOND);
        memWrenNext = 1'b0;
        memAddrNext = mem_address;
        memDataNext = mem_data;
        if (nextState == WRITEBACK) begin
            memWrenNext = 1'b1;
            memAddrNext = {tagMem[reqIndex][victimSel], reqIndex};
            memDataNext = dataMem[reqIndex][victimSel];
        end else if ((nextState == FILL) && !reqWren) begin
            memAddrNext = reqAddr;
        end
    end

    // Output registers, request latch, line storage and statistics
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ready       <= 1'b1;
            valid       <= 1'b0;
            q           <= '0;
            hit         <= 1'b0;
            hit_count   <= '0;
            miss_count  <= '0;
            mem_address <= '0;
            mem_data    <= '0;
            mem_wren    <= 1'b0;
            reqAddr     <= '0;
            reqData     <= '0;
            reqWren     <= 1'b0;
            tagMem      <= '0;
            dataMem     <= '0;
            validBits   <= '0;
            dirtyBits   <= '0;
            lruBits     <= '0;
            victimWay   <= 1'b0;
            fillCnt     <= '0;
            respData    <= '0;
            respHit     <= 1'b0;
        end else begin
            ready       <= readyNext;
            valid       <= validNext;
            mem_wren    <= memWrenNext;
            mem_address <= memAddrNext;
            mem_data    <= memDataNext;
            if (state == RESPOND) begin
                q   <= respData;
                hit <= respHit;
            end
            case (state)
                IDLE: begin
                    if (req && ready) begin
                        reqAddr <= address;
                        reqData <= data;
                        reqWren <= wren;
                    end
                end
                LOOKUP: begin
                    victimWay <= victimSel;
                    fillCnt   <= '0;
                    respHit   <= lookupHit;
                    if (lookupHit) begin
                        lruBits[reqIndex] <= ~hitWay;
                        if (!(&hit_count)) hit_count <= hit_count + STAT_W'(1);
                        if (reqWren) begin
                            dataMem[reqIndex][hitWay]   <= reqData;
                            dirtyBits[reqIndex][hitWay] <= 1'b1;
                            respData                    <= reqData;
                        end else begin
                            respData <= dataMem[reqIndex][hitWay];
                        end
                    end else begin
                        if (!(&miss_count)) miss_count <= miss_count + STAT_W'(1);
                    end
                end
                FILL: begin
                    if (fillDone) begin
                        tagMem[reqIndex][victimWay]    <= reqTag;
                        validBits[reqIndex][victimWay] <= 1'b1;
                        dirtyBits[reqIndex][victimWay] <= reqWren;
                        dataMem[reqIndex][victimWay]   <= reqWren ? reqData : mem_q;
                        respData                       <= reqWren ? reqData : mem_q;
                        lruBits[reqIndex]              <= ~victimWay;
                    end else begin
                        fillCnt <= fillCnt + LAT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
